// File: rtl/timer_pkg.sv
// Shared constants, the BCD digit type and the per-digit modulus helper
// for the multi-digit BCD down-timer.
package timer_pkg;

  localparam int BCD_W        = 4;
  localparam int BCD_MAX      = 9;
  localparam int SEC_TENS_MAX = 5;

  typedef logic [BCD_W-1:0] bcd_t;

  // Digit 1 is the seconds-tens position when the timer runs in MM:SS mode.
  function automatic int digit_mod(input int idx, input int mmss);
    return ((mmss != 0) && (idx == 1)) ? (SEC_TENS_MAX + 1) : (BCD_MAX + 1);
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One modulo-MOD BCD down-counting digit: clamps out-of-range preset values,
// decrements on step and wraps from 0 to MOD-1.
module bcd_digit_cell
  import timer_pkg::*;
#(
  parameter int MOD = 10
) (
  input  logic       clk,
  input  logic       clearn,
  input  logic       load_i,
  input  logic       step_i,
  input  logic [3:0] din_i,
  output logic [3:0] q_o,
  output logic       zero_o,
  output logic       clamp_o
);

  localparam bcd_t TOP = bcd_t'(MOD - 1);

  bcd_t q_q, q_d;
  bcd_t ld_val;

  assign clamp_o = (din_i > TOP);
  assign ld_val  = clamp_o ? TOP : din_i;

  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = ld_val;
    end else if (step_i) begin
      q_d = (q_q == 4'd0) ? TOP : (q_q - 4'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (!clearn) q_q <= '0;
    else         q_q <= q_d;
  end

  assign q_o    = q_q;
  assign zero_o = (q_q == 4'd0);

endmodule

// File: rtl/bcd_down_timer.sv
// Multi-digit BCD down-timer with borrow chain, done pulse and load-range flag.
// Define ZERO_STOP_EN to hold at zero instead of wrapping to the all-max value.
module bcd_down_timer
  import timer_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int MMSS   = 1
) (
  input  logic                  clk,
  input  logic                  clearn,
  input  logic [4*DIGITS-1:0]   data,
  input  logic                  load,
  input  logic                  en,
  output logic [4*DIGITS-1:0]   count,
  output logic                  zero,
  output logic                  tc,
  output logic                  done,
  output logic                  load_err
);

  logic [DIGITS-1:0] dz;
  logic [DIGITS-1:0] lz;
  logic [DIGITS-1:0] step;
  logic [DIGITS-1:0] clamp;
  logic              cnt_en;
  logic              one;
  logic              done_q, done_d;
  logic              load_err_q, load_err_d;

  assign zero = &dz;
  assign tc   = en & zero;

`ifdef ZERO_STOP_EN
  assign cnt_en = en & ~zero;
`else
  assign cnt_en = en;
`endif

  // lz[i] is high when every digit below i is zero, i.e. a borrow reaches digit i.
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    if (i == 0) begin : g_lsd
      assign lz[i] = 1'b1;
    end else begin : g_upper
      assign lz[i] = lz[i-1] & dz[i-1];
    end

    assign step[i] = cnt_en & load & lz[i];

    bcd_digit_cell #(
      .MOD(digit_mod(i, MMSS))
    ) u_cell (
      .clk    (clk),
      .clearn (clearn),
      .load_i (~load),
      .step_i (step[i]),
      .din_i  (data[4*i +: 4]),
      .q_o    (count[4*i +: 4]),
      .zero_o (dz[i]),
      .clamp_o(clamp[i])
    );
  end

  // Only a decrement from 0..01 lands on zero; a wrap out of zero never does.
  assign one    = (count[3:0] == 4'd1) & (&dz[DIGITS-1:1]);
  assign done_d = load & cnt_en & one;

  assign load_err_d = load ? load_err_q : (|clamp);

  always_ff @(posedge clk) begin
    if (!clearn) begin
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      done_q     <= done_d;
      load_err_q <= load_err_d;
    end
  end

  assign done     = done_q;
  assign load_err = load_err_q;

endmodule

// File: doc/bcd_down_timer.md
Name: bcd_down_timer

Overview:
- Parametrised multi-digit BCD down-counter. Successor to the single-digit mod-10 counter.
- Cascades DIGITS modulo-N digit cells with internal borrow.
- Optional MM:SS mode: seconds-tens digit counts modulo 6.
- Sits between the keypad/preset logic and the microwave cook-control FSM; provides remaining time, terminal-count and done indications.

Parameters:
- DIGITS, 4, number of BCD digits (>=2); digit 0 is least significant.
- MMSS, 1, 1: digit 1 is modulo 6 (seconds tens); 0: all digits modulo 10.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- clearn  in  1  synchronous active-low reset.
- data  in  4*DIGITS  preset value, packed BCD; digit i at bits [4i+3:4i].
- load  in  1  active-low synchronous load of data.
- en  in  1  active-high count enable (one decrement per enabled cycle).
- count  out  4*DIGITS  current value, packed BCD, registered.
- zero  out  1  combinational; 1 when count == 0.
- tc  out  1  combinational; en & zero.
- done  out  1  registered one-cycle pulse when a decrement reaches zero.
- load_err  out  1  registered; 1 if the last load contained an out-of-range digit.

Behaviour:
- Reset: clk is the single clock; clearn is synchronous, active-low. When clearn=0 at a rising edge: count=0, done=0, load_err=0. Highest priority.
- Priority per edge: clearn low > load low > en high > hold. Load overrides en; this differs from the previous counter.
- Modulus: MOD_i = 6 for i==1 when MMSS=1; otherwise 10.
- Load (load=0):
  - Each digit takes data digit i, clamped to MOD_i-1 if larger (e.g. 0xC -> 9; 7 in an MMSS seconds-tens digit -> 5).
  - load_err = OR of all clamp events; held until the next load or reset.
  - done=0 on the load cycle.
- Decrement (load=1, en=1, count != 0):
  - Digit 0 always steps.
  - Digit i steps only when digits 0..i-1 are all zero (borrow chain, same cycle).
  - A stepping digit at 0 wraps to MOD_i-1; otherwise it decrements by 1.
  - Example: 10:00 -> 09:59 in one cycle with MMSS=1.
- Done pulse:
  - done=1 in the cycle after an edge where a decrement moved count from nonzero to zero (i.e. count was 0..01).
  - Otherwise done=0.
  - No done on load of zero or reset.
- At zero with en=1: behaviour set by ZERO_STOP_EN (see below).
- tc and zero are combinational from registered count, so tc is the same-cycle view usable for cascading.
- Latency: count updates one edge after load/en sampled; done is registered alongside the transition edge.
- Reset mid-count overrides everything that edge; count resumes only after a new load.

Optional Feature:
- Macro: ZERO_STOP_EN.
- Defined: at count==0, en is ignored; count holds at 0; done does not re-fire; tc stays 1 while en=1.
- Undefined: at count==0 with en=1, all digits wrap to MOD_i-1 (99:59 for DIGITS=4, MMSS=1), matching the previous counter's wrap semantics; done fires only on reaching zero, never on wrapping.

Decomposition:
- Shared package timer_pkg:
  - BCD_W=4, BCD_MAX=9, SEC_TENS_MAX=5.
  - A typedef for a packed BCD digit.
  - A function returning MOD_i for a given index and MMSS.
- Sub-module bcd_digit_cell: one parametrised modulo-MOD digit with clamp-on-load, step input, and zero output. It is instantiated DIGITS times in a generate loop. Borrow AND-chain, done and load_err logic remain in the top.

Test Plan:
- Reset: clearn=0 one edge with load=0, en=1 -> count=0x0000, done=0, load_err=0; zero=1, tc=1.
- Load and borrow, MMSS=1: load 0x1000, then en=1 one cycle -> 0x0959; next cycle -> 0x0958.
- Done pulse: load 0x0002, en=1 two cycles:
  - count 0x0001 then 0x0000.
  - done=1 exactly one cycle, coincident with count first reading 0x0000.
  - tc=1 while en stays high.
- Clamp: load 0x0C7A with MMSS=1 -> count=0x0959, load_err=1. Next load 0x0130 -> load_err=0.
- Priority: load=0 and en=1 same edge with data 0x0005 -> count=0x0005 (no decrement). clearn=0 with load=0 -> count=0.
- At zero with en=1 for 3 cycles:
  - ZERO_STOP_EN defined: count stays 0x0000, done stays 0.
  - ZERO_STOP_EN undefined: count 0x9959, 0x9958, 0x9957, with no done pulse.
